rs_latch_sequencer: RTL and testbench
=====================================

// Module: rs_latch_sequencer
// PURPOSE
//   Controller that shares one gated RS latch (R, S, gating clock, Q) between two requesters.
//   - "set" requester: asks for Q=1. "clear" requester: asks for Q=0.
//   - Arbitrates between the two requesters.
//   - Runs a timed setup / pulse / hold sequence on the latch inputs.
//   - Never drives R=1 and S=1 together.
//   - Sits between board-level request logic (debounced SW/KEY) and the latch instance on the DE board.
// PARAMETERS
//   SETUP_CYC  2   cycles R/S are held stable with latch_clk=0 before the pulse (>=1)
//   PULSE_CYC  4   cycles latch_clk is held high (>=1)
//   HOLD_CYC   2   cycles R/S are held stable after latch_clk falls (>=1)
//   CNT_W      8   width of op_count
// PORTS
//   CLOCK_50   in   1      system clock; all state changes on the rising edge
//   RST_N      in   1      asynchronous, active-low reset
//   set_req    in   1      request Q=1; level, held until set_ack
//   clr_req    in   1      request Q=0; level, held until clr_ack
//   set_ack    out  1      one-cycle pulse: set operation complete
//   clr_ack    out  1      one-cycle pulse: clear operation complete
//   latch_clk  out  1      latch gating clock (Clk input of the latch)
//   latch_s    out  1      latch S input
//   latch_r    out  1      latch R input
//   latch_q    in   1      latch Q, fed back (used only when RSSEQ_VERIFY_EN is defined)
//   busy       out  1      high whenever state != IDLE
//   q_err      out  1      sticky Q-mismatch flag
//   op_count   out  CNT_W  number of completed operations; wraps
// BEHAVIOUR
//   Outputs and reset
//   - All outputs are registered.
//   - While RST_N=0: every output is 0, state=IDLE, last_grant=CLR, so set wins the first tie.
//   - Reset asserted mid-operation aborts the sequence immediately (latch_clk, latch_s, latch_r go to 0).
//     No ack is issued.
//   States: IDLE -> SETUP -> PULSE -> HOLD -> DONE -> IDLE
//   - IDLE: requests are sampled.
//     - Only one request high: grant it.
//     - Both high: grant the one not equal to last_grant (alternating), then update last_grant.
//     - On grant, at the same edge: enter SETUP and load the cycle counter. Drive latch_s=1 for a set
//       grant or latch_r=1 for a clear grant. latch_clk stays 0.
//   - SETUP: lasts SETUP_CYC cycles, then enter PULSE with latch_clk=1.
//   - PULSE: lasts PULSE_CYC cycles, then enter HOLD with latch_clk=0. R/S unchanged.
//   - HOLD: lasts HOLD_CYC cycles, then enter DONE. R/S=0 and the matching ack=1.
//   - DONE: lasts 1 cycle, then IDLE. Ack returns to 0. op_count += 1, wrapping 2^CNT_W-1 -> 0.
//   Latency: with grant at edge k, ack is high for exactly the cycle after edge k+SETUP_CYC+PULSE_CYC+HOLD_CYC
//   (defaults: edge k+8).
//   Request handling
//   - Requests are ignored outside IDLE.
//   - A request that drops mid-operation does not abort it; the ack is still issued.
//   - A request still high when IDLE is re-entered counts as a new request, so requesters must drop
//     their request in the ack cycle.
//   Invariants
//   - latch_s & latch_r == 0 always.
//   - latch_s/latch_r only change while latch_clk=0.
//   - busy == (state != IDLE).
// CONFIGURATION
//   RSSEQ_VERIFY_EN defined
//   - latch_q is sampled on the final HOLD cycle: expected 1 after a set, 0 after a clear.
//   - On mismatch, q_err is set on the DONE-entry edge and stays set until RST_N.
//   - The ack is still issued.
//   RSSEQ_VERIFY_EN undefined
//   - q_err is tied to 0; latch_q is unused.
//   - Sequencing is identical in both cases.
// TESTING
//   1. Reset: RST_N=0 mid-PULSE -> next sample: latch_clk=latch_s=latch_r=0, busy=0, no ack, op_count unchanged.
//   2. Single set: set_req=1 at edge k (defaults) -> latch_s=1 from k; latch_clk=1 over edges k+2..k+5;
//      latch_s=0 and set_ack=1 for one cycle after edge k+8; op_count=1.
//   3. Tie: set_req=clr_req=1 held after reset -> grants alternate set, clr, set.
//      latch_s and latch_r are never both 1.
//   4. Ignore while busy: clr_req pulsed only during a set's PULSE -> no clear operation, no clr_ack.
//   5. Wrap: CNT_W=2, 5 operations -> op_count sequence 1,2,3,0,1.
//   6. Verify (RSSEQ_VERIFY_EN): latch_q model forced to 0 during a set -> q_err=1 from DONE entry,
//      set_ack still issued; q_err stays 1 through the next good clear and clears only on RST_N.

Source files
------------

// File: rtl/rs_latch_sequencer_if.sv
// Request/acknowledge and latch-side signal bundle for rs_latch_sequencer.
`timescale 1ns/1ps

interface rs_latch_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             set_req;
  logic             clr_req;
  logic             set_ack;
  logic             clr_ack;
  logic             latch_clk;
  logic             latch_s;
  logic             latch_r;
  logic             latch_q;
  logic             busy;
  logic             q_err;
  logic [CNT_W-1:0] op_count;

  modport master (
    output set_req, clr_req, latch_q,
    input  set_ack, clr_ack, latch_clk, latch_s, latch_r, busy, q_err, op_count
  );

  modport slave (
    input  set_req, clr_req, latch_q,
    output set_ack, clr_ack, latch_clk, latch_s, latch_r, busy, q_err, op_count
  );
endinterface

// File: rtl/rs_latch_sequencer.sv
// Shares one gated RS latch between a set and a clear requester with a timed setup/pulse/hold sequence.
// Optional Q read-back check is enabled by defining RSSEQ_VERIFY_EN.
`timescale 1ns/1ps

module rs_latch_sequencer #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 2,
  parameter int CNT_W     = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 RST_N,
  rs_latch_sequencer_if.slave  bus
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [TW-1:0]    tmr_r, tmr_s;
  logic             last_set_r, last_set_s;
  logic             op_set_r, op_set_s;
  logic             s_r, s_s;
  logic             r_r, r_s;
  logic             clk_r, clk_s;
  logic             set_ack_r, set_ack_s;
  logic             clr_ack_r, clr_ack_s;
  logic             busy_r, busy_s;
  logic             q_err_r, q_err_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             grant_set_s;

`ifndef RSSEQ_VERIFY_EN
  logic unused_latch_q_s;
  assign unused_latch_q_s = bus.latch_q;
`endif

  // Next-state and next-output decode; R and S are only ever loaded while latch_clk is low.
  always_comb begin
    state_s     = state_r;
    tmr_s       = tmr_r;
    last_set_s  = last_set_r;
    op_set_s    = op_set_r;
    s_s         = s_r;
    r_s         = r_r;
    clk_s       = clk_r;
    set_ack_s   = 1'b0;
    clr_ack_s   = 1'b0;
    q_err_s     = q_err_r;
    cnt_s       = cnt_r;
    grant_set_s = bus.set_req && (!bus.clr_req || !last_set_r);

    case (state_r)
      ST_IDLE: begin
        if (bus.set_req || bus.clr_req) begin
          state_s    = ST_SETUP;
          tmr_s      = TW'(SETUP_CYC - 1);
          op_set_s   = grant_set_s;
          last_set_s = grant_set_s;
          s_s        = grant_set_s;
          r_s        = !grant_set_s;
          clk_s      = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (tmr_r == '0) begin
          state_s = ST_PULSE;
          tmr_s   = TW'(PULSE_CYC - 1);
          clk_s   = 1'b1;
        end else begin
          tmr_s = tmr_r - TW'(1);
        end
      end
      ST_PULSE: begin
        if (tmr_r == '0) begin
          state_s = ST_HOLD;
          tmr_s   = TW'(HOLD_CYC - 1);
          clk_s   = 1'b0;
        end else begin
          tmr_s = tmr_r - TW'(1);
        end
      end
      ST_HOLD: begin
        if (tmr_r == '0) begin
          state_s   = ST_DONE;
          s_s       = 1'b0;
          r_s       = 1'b0;
          set_ack_s = op_set_r;
          clr_ack_s = !op_set_r;
`ifdef RSSEQ_VERIFY_EN
          if (bus.latch_q != op_set_r) begin
            q_err_s = 1'b1;
          end else begin
            q_err_s = q_err_r;
          end
`endif
        end else begin
          tmr_s = tmr_r - TW'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        cnt_s   = cnt_r + CNT_W'(1);
      end
      default: begin
        state_s = ST_IDLE;
        s_s     = 1'b0;
        r_s     = 1'b0;
        clk_s   = 1'b0;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State and registered outputs; reset aborts any sequence in progress.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= ST_IDLE;
      tmr_r      <= '0;
      last_set_r <= 1'b0;
      op_set_r   <= 1'b0;
      s_r        <= 1'b0;
      r_r        <= 1'b0;
      clk_r      <= 1'b0;
      set_ack_r  <= 1'b0;
      clr_ack_r  <= 1'b0;
      busy_r     <= 1'b0;
      q_err_r    <= 1'b0;
      cnt_r      <= '0;
    end else begin
      state_r    <= state_s;
      tmr_r      <= tmr_s;
      last_set_r <= last_set_s;
      op_set_r   <= op_set_s;
      s_r        <= s_s;
      r_r        <= r_s;
      clk_r      <= clk_s;
      set_ack_r  <= set_ack_s;
      clr_ack_r  <= clr_ack_s;
      busy_r     <= busy_s;
      q_err_r    <= q_err_s;
      cnt_r      <= cnt_s;
    end
  end

  assign bus.latch_s   = s_r;
  assign bus.latch_r   = r_r;
  assign bus.latch_clk = clk_r;
  assign bus.set_ack   = set_ack_r;
  assign bus.clr_ack   = clr_ack_r;
  assign bus.busy      = busy_r;
  assign bus.q_err     = q_err_r;
  assign bus.op_count  = cnt_r;

endmodule

// File: tb/tb_rs_latch_sequencer.sv
// Self-checking bench for rs_latch_sequencer: vector table, corner-case sequences and random traffic
// against a timeline reference model. Also exercises the RSSEQ_VERIFY_EN build.
`timescale 1ns/1ps

module tb_rs_latch_sequencer;
  localparam int S_C   = 2;
  localparam int P_C   = 4;
  localparam int H_C   = 2;
  localparam int T_ACK = S_C + P_C + H_C;
`ifdef RSSEQ_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic RST_N    = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  rs_latch_sequencer_if #(.CNT_W(8)) bus ();
  rs_latch_sequencer_if #(.CNT_W(2)) bus2 ();

  rs_latch_sequencer #(.SETUP_CYC(S_C), .PULSE_CYC(P_C), .HOLD_CYC(H_C), .CNT_W(8)) dut (
    .CLOCK_50(CLOCK_50), .RST_N(RST_N), .bus(bus));
  rs_latch_sequencer #(.SETUP_CYC(S_C), .PULSE_CYC(P_C), .HOLD_CYC(H_C), .CNT_W(2)) dut2 (
    .CLOCK_50(CLOCK_50), .RST_N(RST_N), .bus(bus2));

  // Gated RS latch model; q_kill forces the fed-back Q low to provoke a mismatch.
  logic q_lat  = 1'b0;
  logic q_kill = 1'b0;
  always @(posedge CLOCK_50) begin
    if (bus.latch_clk && bus.latch_s) q_lat <= 1'b1;
    else if (bus.latch_clk && bus.latch_r) q_lat <= 1'b0;
  end
  assign bus.latch_q  = q_lat & ~q_kill;
  assign bus2.latch_q = bus.latch_q;
  assign bus2.set_req = bus.set_req;
  assign bus2.clr_req = bus.clr_req;

  int checks = 0;
  int errors = 0;

  // Reference model: an operation is a timeline measured in cycles since its grant edge.
  bit m_act, m_set, m_last_set, m_qerr;
  int m_t, m_cnt;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_set = 1'b0; m_last_set = 1'b0; m_qerr = 1'b0; m_t = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit sreq, input bit creq, input bit q);
    if (!m_act) begin
      if (sreq || creq) begin
        m_set      = (sreq && creq) ? !m_last_set : sreq;
        m_last_set = m_set;
        m_act      = 1'b1;
        m_t        = 0;
      end
    end else begin
      m_t++;
      if (m_t == T_ACK && VERIFY && (q != m_set)) m_qerr = 1'b1;
      if (m_t == T_ACK + 1) begin
        m_act = 1'b0;
        m_cnt++;
      end
    end
  endtask

  task automatic compare_all();
    check("latch_s",   bus.latch_s,   int'(m_act && m_set && m_t < T_ACK));
    check("latch_r",   bus.latch_r,   int'(m_act && !m_set && m_t < T_ACK));
    check("latch_clk", bus.latch_clk, int'(m_act && m_t >= S_C && m_t < S_C + P_C));
    check("set_ack",   bus.set_ack,   int'(m_act && m_set && m_t == T_ACK));
    check("clr_ack",   bus.clr_ack,   int'(m_act && !m_set && m_t == T_ACK));
    check("busy",      bus.busy,      int'(m_act));
    check("q_err",     bus.q_err,     int'(m_qerr));
    check("op_count",  bus.op_count,  m_cnt % 256);
    check("op_count2", bus2.op_count, m_cnt % 4);
    check("busy2",     bus2.busy,     int'(m_act));
    check("s_and_r",   bus.latch_s & bus.latch_r, 0);
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    if (RST_N) model_edge(bus.set_req, bus.clr_req, bus.latch_q);
    else model_reset();
    @(negedge CLOCK_50);
    compare_all();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;
    model_reset();
    step();
    step();
    RST_N = 1'b1;
  endtask

  // Raise one request, hold it until its ack, drop it in the ack cycle (returns in that cycle).
  task automatic do_op(input bit is_set);
    bit got = 1'b0;
    if (is_set) bus.set_req = 1'b1; else bus.clr_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if ((is_set && bus.set_ack) || (!is_set && bus.clr_ack)) got = 1'b1;
    end
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;
    check("op_ack_seen", int'(got), 1);
  endtask

  typedef struct {
    bit sreq;
    bit e_s, e_clk, e_sa, e_busy;
    int e_cnt;
  } vec_t;

  vec_t tbl[12];
  int   wrap_exp[5];
  int   acks[$];

  initial begin
    // Single set from idle: grant edge k is row 0.
    for (int i = 0; i < 12; i++) begin
      tbl[i].sreq   = (i <= 8);
      tbl[i].e_s    = (i <= 7);
      tbl[i].e_clk  = (i >= 2 && i <= 5);
      tbl[i].e_sa   = (i == 8);
      tbl[i].e_busy = (i <= 8);
      tbl[i].e_cnt  = (i >= 9) ? 1 : 0;
    end
    wrap_exp = '{1, 2, 3, 0, 1};

    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;
    model_reset();
    @(negedge CLOCK_50);
    compare_all();
    @(negedge CLOCK_50);
    RST_N = 1'b1;

    // Reset asserted in the middle of PULSE.
    bus.set_req = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("pulse_before_reset", bus.latch_clk, 1);
    #5;
    RST_N = 1'b0;
    model_reset();
    #1;
    check("rst_latch_clk", bus.latch_clk, 0);
    check("rst_latch_s",   bus.latch_s,   0);
    check("rst_busy",      bus.busy,      0);
    check("rst_set_ack",   bus.set_ack,   0);
    check("rst_op_count",  bus.op_count,  0);
    bus.set_req = 1'b0;
    step();
    RST_N = 1'b1;
    step();

    // Vector table: timed set sequence.
    for (int i = 0; i < 12; i++) begin
      bus.set_req = tbl[i].sreq;
      bus.clr_req = 1'b0;
      step();
      check("tbl_latch_s",   bus.latch_s,   int'(tbl[i].e_s));
      check("tbl_latch_r",   bus.latch_r,   0);
      check("tbl_latch_clk", bus.latch_clk, int'(tbl[i].e_clk));
      check("tbl_set_ack",   bus.set_ack,   int'(tbl[i].e_sa));
      check("tbl_busy",      bus.busy,      int'(tbl[i].e_busy));
      check("tbl_op_count",  bus.op_count,  tbl[i].e_cnt);
    end

    // Tie after reset: grants alternate set, clr, set.
    do_reset();
    bus.set_req = 1'b1;
    bus.clr_req = 1'b1;
    for (int i = 0; i < 40 && acks.size() < 3; i++) begin
      step();
      if (bus.set_ack) acks.push_back(1);
      if (bus.clr_ack) acks.push_back(0);
    end
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;
    check("tie_ack_count", acks.size(), 3);
    for (int i = 0; i < acks.size() && i < 3; i++) check("tie_order", acks[i], (i % 2 == 0) ? 1 : 0);
    step();

    // Clear request pulsed only while a set is in PULSE is ignored.
    begin
      int n_clr = 0;
      int n_set = 0;
      bus.set_req = 1'b1;
      for (int i = 0; i < 14; i++) begin
        bus.clr_req = m_act && m_t >= 2 && m_t <= 4;
        step();
        if (bus.clr_ack) n_clr++;
        if (bus.set_ack) begin
          n_set++;
          bus.set_req = 1'b0;
        end
      end
      bus.clr_req = 1'b0;
      check("ignore_clr_ack", n_clr, 0);
      check("ignore_set_ack", n_set, 1);
      check("ignore_idle", bus.busy, 0);
    end

    // Q read-back: forced-low Q during a set.
    do_reset();
    q_kill = 1'b1;
    do_op(1'b1);
    check("verify_set_ack", bus.set_ack, 1);
    check("verify_q_err", bus.q_err, int'(VERIFY));
    q_kill = 1'b0;
    step();
    do_op(1'b0);
    check("verify_q_err_sticky", bus.q_err, int'(VERIFY));
    step();
    do_reset();
    check("verify_q_err_reset", bus.q_err, 0);

    // Two-bit counter wraps 1,2,3,0,1.
    for (int i = 0; i < 5; i++) begin
      do_op(i % 2 == 0);
      step();
      check("wrap_count", bus2.op_count, wrap_exp[i]);
    end

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        RST_N = 1'b0;
        model_reset();
        #1;
        compare_all();
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        step();
        RST_N = 1'b1;
      end
      if (bus.set_ack) bus.set_req = 1'b0;
      else if (!bus.set_req && $urandom_range(0, 3) == 0) bus.set_req = 1'b1;
      else if (bus.set_req && bus.busy && $urandom_range(0, 31) == 0) bus.set_req = 1'b0;
      if (bus.clr_ack) bus.clr_req = 1'b0;
      else if (!bus.clr_req && $urandom_range(0, 3) == 0) bus.clr_req = 1'b1;
      else if (bus.clr_req && bus.busy && $urandom_range(0, 31) == 0) bus.clr_req = 1'b0;
      q_kill = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
